// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arb4_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb4_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arb4_ctrl_if;
  logic [rr_arb4_pkg::NUM_REQ-1:0] req;
  logic                            rel;
  logic [rr_arb4_pkg::NUM_REQ-1:0] gnt;
  logic [rr_arb4_pkg::IDX_W-1:0]   gnt_idx;
  logic                            gnt_vld;
  logic                            timeout;

  modport master (output req, rel, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave  (input req, rel, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_arb4_ctrl_dec2to4_onehot.sv
// Binary index to one-hot decode, forced to all-zero when not enabled.
module dec2to4_onehot
  import rr_arb4_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_oh
);
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bit
      assign o_oh[gi] = i_en & (i_idx == IDX_W'(gi));
    end
  endgenerate
endmodule

// File: rtl/rr_arb4_ctrl.sv
// 4-way round-robin arbiter: IDLE -> GRANT -> GAP with registered one-hot grant.
// Define RR_ARB4_TIMEOUT_EN to enable forced revocation after MAX_HOLD grant cycles.
module rr_arb4_ctrl
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arb4_ctrl_if.slave  arb
);
  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_gnt_idx;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_gnt_vld;

  logic [IDX_W-1:0]     w_cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   w_cand_req;
  logic                 w_win_vld;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_rel_exit;
  logic                 w_force_exit;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_arb4_ctrl: MAX_HOLD must be within 2..255");
  end

  // Candidate k is the requester at distance k from the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_cand_idx[gi] = r_ptr + IDX_W'(gi);
      assign w_cand_req[gi] = arb.req[w_cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand_idx[k];
      end
    end
  end

  dec2to4_onehot u_dec (
    .i_idx (w_win_idx),
    .i_en  (w_win_vld),
    .o_oh  (w_win_oh)
  );

  // Owner dropping its request is treated exactly like an explicit release.
  assign w_rel_exit = arb.rel | ~arb.req[r_gnt_idx];

`ifdef RR_ARB4_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  assign w_force_exit = ~w_rel_exit & (r_hold == HOLD_LAST);
  assign arb.timeout  = r_timeout;
`else
  assign w_force_exit = 1'b0;
  assign arb.timeout  = 1'b0;
`endif

  assign arb.gnt     = r_gnt;
  assign arb.gnt_idx = r_gnt_idx;
  assign arb.gnt_vld = r_gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_gnt_vld <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
      r_hold    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB4_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_state   <= GRANT;
            r_gnt     <= w_win_oh;
            r_gnt_idx <= w_win_idx;
            r_gnt_vld <= 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
            r_hold    <= '0;
`endif
          end
        end
        GRANT: begin
          if (w_rel_exit || w_force_exit) begin
            r_state   <= GAP;
            r_ptr     <= r_gnt_idx + IDX_W'(1);
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
            r_timeout <= w_force_exit;
          end else begin
            r_hold    <= r_hold + HOLD_W'(1);
`endif
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Directed self-checking bench for rr_arb4_ctrl (MAX_HOLD=4).
module tb_rr_arb4_ctrl;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rr_arb4_ctrl_if arb ();

  rr_arb4_ctrl #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    chk({tag, ".gnt"}, 32'(arb.gnt), 32'(oh));
    chk({tag, ".idx"}, 32'(arb.gnt_idx), 32'(idx));
    chk({tag, ".vld"}, 32'(arb.gnt_vld), 32'd1);
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, ".gnt"}, 32'(arb.gnt), 32'd0);
    chk({tag, ".idx"}, 32'(arb.gnt_idx), 32'd0);
    chk({tag, ".vld"}, 32'(arb.gnt_vld), 32'd0);
    chk({tag, ".to"}, 32'(arb.timeout), 32'(exp_to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    rst_n   = 1'b0;
    arb.req = 4'b0000;
    arb.rel = 1'b0;
    #23;
    chk_idle("reset", 1'b0);
    $display("txn reset: outputs idle");

    // Single requester 2: grant one cycle after first arbitration edge.
    rst_n   = 1'b1;
    arb.req = 4'b0100;
    step();
    chk_grant("single2", 2);
    step();
    chk_grant("single2_hold", 2);
    arb.req = 4'b0000;
    step();
    chk_idle("single2_gap", 1'b0);
    step();
    chk_idle("single2_idle", 1'b0);
    $display("txn single requester 2 granted and released");

    // All four requesting, release pulsed once per grant.
    do_reset();
    arb.req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      chk_grant($sformatf("rot%0d", n), seq[n]);
      step();
      chk_grant($sformatf("rot%0d_hold", n), seq[n]);
      arb.rel = 1'b1;
      step();
      arb.rel = 1'b0;
      chk_idle($sformatf("rot%0d_gap", n), 1'b0);
      step();
      step();
      $display("txn rotate grant %0d -> owner %0d", n, seq[n]);
    end
    chk_grant("rot5", 1);

    // Owner 1 drops its request; ptr=2 and bit 2 clear so 3 wins.
    arb.req = 4'b1010;
    step();
    chk_grant("drop_hold", 1);
    arb.req = 4'b1000;
    step();
    chk_idle("drop_gap", 1'b0);
    step();
    step();
    chk_grant("drop_next", 3);
    $display("txn owner 1 dropped request, next owner 3");

    // Asynchronous reset in the middle of a grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 1'b0);
    #1;
    rst_n = 1'b1;
    step();
    chk_grant("post_rst", 3);
    $display("txn async reset mid-grant, regrant to 3");
    arb.req = 4'b0000;
    step();
    step();

`ifdef RR_ARB4_TIMEOUT_EN
    // Forced revocation after MAX_HOLD cycles.
    do_reset();
    arb.req = 4'b0001;
    step();
    for (int c = 0; c < 4; c++) begin
      chk_grant($sformatf("to_hold%0d", c), 0);
      chk($sformatf("to_hold%0d.to", c), 32'(arb.timeout), 32'd0);
      if (c < 3) step();
    end
    step();
    chk_idle("to_gap", 1'b1);
    step();
    chk_idle("to_idle", 1'b0);
    step();
    chk_grant("to_regrant", 0);
    $display("txn timeout revoke of owner 0");

    // Release in the final allowed cycle beats the limit.
    step();
    step();
    step();
    chk_grant("rel_last", 0);
    arb.rel = 1'b1;
    step();
    arb.rel = 1'b0;
    chk_idle("rel_last_gap", 1'b0);
    $display("txn release coincident with limit, no timeout");
`else
    // Without timeout the owner holds well past MAX_HOLD.
    do_reset();
    arb.req = 4'b0001;
    step();
    for (int c = 0; c < 10; c++) begin
      chk_grant($sformatf("nt_hold%0d", c), 0);
      chk($sformatf("nt_hold%0d.to", c), 32'(arb.timeout), 32'd0);
      step();
    end
    arb.rel = 1'b1;
    step();
    arb.rel = 1'b0;
    chk_idle("nt_gap", 1'b0);
    $display("txn indefinite hold then release");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
